io_dma_regs: RTL
================

IO_DMA_REGS -- requirements
Module: io_dma_regs

Interface
REQ-001 Parameter NUM_PADS, default 2, number of serial controller ports (1..4).
REQ-002 Parameter PAD_BITS, default 8, shift-register length per pad (8..24).
REQ-003 Parameter DMA_LEN, default 256, bytes per DMA transfer (power of two, 2..256).
REQ-004 Ports: clk  in  1  CPU clock, one CPU cycle per rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-005 Register bus: addr  in  5  register offset; data_in  in  8  write data; sel  in  1  one-cycle access strobe; rd  in  1  1=read, 0=write; data_out  out  8  registered read data.
REQ-006 Pad inputs: pad_state  in  NUM_PADS*PAD_BITS  parallel button state, pad k at [k*PAD_BITS +: PAD_BITS], bit 0 shifted first.
REQ-007 DMA ports: dma_busy  out  1  halts CPU; dma_addr  out  16  source address; dma_rd  out  1  source read strobe; dma_rdata  in  8  source data, valid in the dma_rd cycle; dma_wr  out  1  write strobe to OAM data port; dma_wdata  out  8  OAM write data.

Function
REQ-008 Clock and reset: one clock, clk; reset rst_n asynchronous, active-low.
REQ-009 All state updates on rising clk; sel is honoured only when dma_busy=0.
REQ-010 Write offset 0x16: strobe <= data_in[0]; every pad shift register loads pad_state the same cycle.
REQ-011 While strobe=1, all shift registers reload pad_state every cycle; reads return bit 0 of the live value without shifting.
REQ-012 Read 0x16: data_out[0]=pad0 bit0, data_out[1]=pad2 bit0 (0 if NUM_PADS<3), data_out[7:2]=0; with strobe=0 those registers shift right, inserting 1.
REQ-013 Read 0x17: same as REQ-012 for pad1 (bit0) and pad3 (bit1); 0 and no shift for absent pads.
REQ-014 After PAD_BITS shifts, reads return 1 on each present pad bit until the next reload.
REQ-015 data_out is valid the cycle after a read sel and holds until the next read; reads of other offsets return 0x00.
REQ-016 Write 0x14 with dma_busy=0: latch page=data_in; start DMA next cycle.
REQ-017 DMA FSM: IDLE -> HALT (1 cycle) -> [ALIGN, 1 cycle, per REQ-025] -> READ <-> WRITE, DMA_LEN pairs -> IDLE.
REQ-018 READ: dma_rd=1, dma_addr={page, idx}, idx 8-bit zero-extended from 0; capture dma_rdata at cycle end.
REQ-019 WRITE: dma_wr=1, dma_wdata=captured byte; idx increments; after idx=DMA_LEN-1 the FSM returns to IDLE.
REQ-020 dma_busy=1 in every non-IDLE state; dma_rd and dma_wr never both high; both 0 in IDLE/HALT/ALIGN.
REQ-021 Boundaries: idx never crosses page; writes to 0x14 or 0x16 and reads during dma_busy are ignored; pad state is held during DMA.
REQ-022 A free-running parity flop toggles every clk cycle (0 after reset).

Reset
REQ-023 rst_n low: data_out=0, strobe=0, shift registers all 1s, FSM IDLE, dma_busy=dma_rd=dma_wr=0, dma_addr=0, dma_wdata=0, idx=0, parity=0.
REQ-024 Reset mid-DMA aborts immediately; no further dma_rd/dma_wr after rst_n rises until a new 0x14 write.

Configuration
REQ-025 Macro IO_DMA_ODD_ALIGN_EN defined: ALIGN entered when parity=1 in HALT, so a transfer is 2*DMA_LEN+1 or +2 cycles; undefined: ALIGN never entered, always 2*DMA_LEN+1 cycles.

Verification
REQ-026 rst_n low mid-DMA at idx=0x40 -> dma_busy=0 same cycle asynchronously, outputs at reset values, no strobe afterwards.
REQ-027 pad_state pad0=0xA5; write 0x16 data 1 then 0; 10 reads of 0x16 -> bit0 sequence 1,0,1,0,0,1,0,1,1,1.
REQ-028 strobe=1, pad0 bit0 toggles 0->1; read 0x16 twice -> 0 then 1, no shifting.
REQ-029 Write 0x14 data 0x02, parity=0, source returns addr[7:0] -> dma_wr carries 0x00..0xFF in order, dma_addr 0x0200..0x02FF, dma_busy high 513 cycles.
REQ-030 With IO_DMA_ODD_ALIGN_EN, start with parity=1 in HALT -> dma_busy high 514 cycles; without macro -> 513.
REQ-031 During DMA: write 0x14 data 0x07 and read 0x16 -> page stays 0x02, pad registers unshifted, data_out unchanged.

Source files
------------

// File: rtl/io_dma_regs.sv
// Controller-pad shift registers plus sprite DMA engine; IO_DMA_ODD_ALIGN_EN adds an odd-cycle ALIGN state.
// Latency: register reads appear on data_out one cycle after sel; DMA starts the cycle after a 0x14 write.
// Backpressure: none on the register bus; dma_busy halts the CPU and masks sel for the whole transfer.
module io_dma_regs #(
  parameter int NUM_PADS = 2,
  parameter int PAD_BITS = 8,
  parameter int DMA_LEN  = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [4:0]                   addr,
  input  logic [7:0]                   data_in,
  input  logic                         sel,
  input  logic                         rd,
  output logic [7:0]                   data_out,
  input  logic [NUM_PADS*PAD_BITS-1:0] pad_state,
  output logic                         dma_busy,
  output logic [15:0]                  dma_addr,
  output logic                         dma_rd,
  input  logic [7:0]                   dma_rdata,
  output logic                         dma_wr,
  output logic [7:0]                   dma_wdata
);

  localparam logic [4:0] OFS_DMA  = 5'h14;
  localparam logic [4:0] OFS_PAD0 = 5'h16;
  localparam logic [4:0] OFS_PAD1 = 5'h17;
  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
`ifdef IO_DMA_ODD_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_HALT, ST_ALIGN, ST_READ, ST_WRITE} state_t;

  state_t              state;
  logic                parity;
  logic                strobe;
  logic [7:0]          page;
  logic [7:0]          idx;
  logic [PAD_BITS-1:0] sr [NUM_PADS];
  logic [3:0]          pad_bit;
  logic                acc;
  logic                wr_dma;
  logic                wr_pad;
  logic                rd_pad0;
  logic                rd_pad1;

  // The CPU is halted during DMA, so any strobe seen then is stale and dropped.
  assign acc     = sel && !dma_busy;
  assign wr_dma  = acc && !rd && (addr == OFS_DMA);
  assign wr_pad  = acc && !rd && (addr == OFS_PAD0);
  assign rd_pad0 = acc && rd && (addr == OFS_PAD0);
  assign rd_pad1 = acc && rd && (addr == OFS_PAD1);

  always_comb begin
    pad_bit = '0;
    for (int k = 0; k < NUM_PADS; k++)
      pad_bit[k] = strobe ? pad_state[k*PAD_BITS] : sr[k][0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe <= 1'b0;
      for (int k = 0; k < NUM_PADS; k++) sr[k] <= '1;
    end else if (!dma_busy) begin
      if (wr_pad) strobe <= data_in[0];
      for (int k = 0; k < NUM_PADS; k++) begin
        if (wr_pad || strobe)
          sr[k] <= pad_state[k*PAD_BITS +: PAD_BITS];
        else if ((k % 2 == 0) ? rd_pad0 : rd_pad1)
          sr[k] <= {1'b1, sr[k][PAD_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      data_out <= 8'h00;
    else if (acc && rd) begin
      if (rd_pad0)      data_out <= {6'b0, pad_bit[2], pad_bit[0]};
      else if (rd_pad1) data_out <= {6'b0, pad_bit[3], pad_bit[1]};
      else              data_out <= 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity <= 1'b0;
    else        parity <= ~parity;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      page      <= 8'h00;
      idx       <= 8'h00;
      dma_busy  <= 1'b0;
      dma_addr  <= 16'h0000;
      dma_rd    <= 1'b0;
      dma_wr    <= 1'b0;
      dma_wdata <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: if (wr_dma) begin
          page     <= data_in;
          state    <= ST_HALT;
          dma_busy <= 1'b1;
        end
        ST_HALT: if (ALIGN_EN && parity) begin
          state <= ST_ALIGN;
        end else begin
          state    <= ST_READ;
          dma_rd   <= 1'b1;
          dma_addr <= {page, idx};
        end
        ST_ALIGN: begin
          state    <= ST_READ;
          dma_rd   <= 1'b1;
          dma_addr <= {page, idx};
        end
        ST_READ: begin
          dma_wdata <= dma_rdata;
          dma_rd    <= 1'b0;
          dma_wr    <= 1'b1;
          state     <= ST_WRITE;
        end
        ST_WRITE: begin
          dma_wr <= 1'b0;
          if (idx == LAST_IDX) begin
            idx      <= 8'h00;
            dma_busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            idx      <= 8'(idx + 8'd1);
            dma_rd   <= 1'b1;
            dma_addr <= {page, 8'(idx + 8'd1)};
            state    <= ST_READ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
